// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
//   Shared types and helpers for reg_bank_arbiter and its round-robin arbiter.
//   rb_state_t : access sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   DATA_W_DEF : default register width
//   rr_next    : round-robin successor of an index modulo n
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } rb_state_t;

  localparam int unsigned DATA_W_DEF = 64;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr and wraps; the
//   pointer itself is stored by the parent.
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    highest-priority index for this decision
//   en        in  1        arbitration enable; no grant when low
//   grant     out NUM_REQ  one-hot grant
//   grant_idx out IDX_W    index of the granted requester
//   any       out 1        a grant was issued
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (en && !any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Shares a bank of DEPTH registers between NUM_REQ requesters. One transaction
//   at a time is accepted round-robin in IDLE, performed in ACCESS and answered
//   with a one-cycle strobe in RESP. This block is the only writer of the bank.
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous, active-low reset
//   req_valid  in   NUM_REQ         per-requester request
//   req_we     in   NUM_REQ         1=write, 0=read
//   req_addr   in   NUM_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         one-hot accept pulse (combinational in IDLE)
//   rsp_valid  out  NUM_REQ         one-hot one-cycle response strobe
//   rsp_rdata  out  DATA_W          read data, or the written data for writes
//   rsp_err    out  1               address >= DEPTH, valid with rsp_valid
//   busy       out  1               sequencer not in IDLE
//   grant_id   out  GRANT_W         index of the current/last grant
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DEPTH   = 8,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [GRANT_W-1:0]          grant_id
);

  rb_state_t state, state_nxt;

  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_any;
  logic               arb_en;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               addr_ok;

  logic [DATA_W-1:0]  bank [DEPTH];

  // Arbitration is also gated by reset so req_ready stays low while reset is held.
  assign arb_en  = (state == IDLE) && reset;
  assign addr_ok = 32'(addr_q) < DEPTH;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = win_onehot;
        if (win_any) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // err_q is cleared in IDLE but still holds during that first IDLE cycle,
  // so the output is qualified with RESP.
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = rdata_q;
  assign grant_id  = grant_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (win_any) begin
            we_q    <= req_we[win_idx];
            addr_q  <= req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[32'(win_idx)*DATA_W +: DATA_W];
            grant_q <= win_idx;
            ptr_q   <= GRANT_W'(rr_next(32'(win_idx), NUM_REQ));
          end
        end
        ACCESS: begin
          if (!addr_ok) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (we_q) begin
            bank[addr_q] <= wdata_q;
            rdata_q      <= wdata_q;
          end else begin
            rdata_q <= bank[addr_q];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Self-checking bench for reg_bank_arbiter (NUM_REQ=4, DEPTH=6). A
//   transaction-level reference model predicts grants, responses and bank
//   contents; directed scenarios are followed by a randomized run.
module tb_reg_bank_arbiter;

  localparam int NR = 4;
  localparam int DP = 6;
  localparam int DW = 64;
  localparam int AW = 3;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [GW-1:0]     grant_id;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .NUM_REQ (NR),
    .DEPTH   (DP),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // requester-side stimulus
  bit            a_act [NR];
  bit            a_we  [NR];
  logic [AW-1:0] a_addr[NR];
  logic [DW-1:0] a_wd  [NR];
  bit            refill;

  // reference model
  logic [DW-1:0] m_bank[8];
  int            m_ptr, m_since, m_gid, m_rsp_id;
  logic [DW-1:0] m_pend, m_last;
  bit            m_pend_err;

  int            acc_id[$];
  int            acc_cyc[$];
  int            last_rsp_cyc;
  logic [DW-1:0] obs_data;
  logic          obs_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = a_act[i];
      req_we[i]              = a_we[i];
      req_addr[i*AW +: AW]   = a_addr[i];
      req_wdata[i*DW +: DW]  = a_wd[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_ptr      = 0;
    m_since    = 3;
    m_gid      = 0;
    m_rsp_id   = 0;
    m_pend     = '0;
    m_last     = '0;
    m_pend_err = 0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    int            win;
    logic [NR-1:0] er, ev;
    drive();
    #1;
    win = -1;
    er  = '0;
    if (m_since >= 3) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (win < 0 && a_act[idx]) win = idx;
      end
    end
    if (win >= 0) er[win] = 1'b1;
    ev = '0;
    if (m_since == 2) begin
      ev[m_rsp_id] = 1'b1;
      m_last       = m_pend;
    end
    chk("req_ready", req_ready, er);
    chk("busy", busy, (m_since == 1 || m_since == 2));
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_rdata", rsp_rdata, m_last);
    chk("grant_id", grant_id, m_gid);
    if (m_since == 2) chk("rsp_err", rsp_err, m_pend_err);
    else              chk("rsp_err_idle", rsp_err, 0);
    if (rsp_valid != 0) begin
      last_rsp_cyc = cyc;
      obs_data     = rsp_rdata;
      obs_err      = rsp_err;
    end
    if (win >= 0) begin
      if (a_addr[win] >= DP) begin
        m_pend     = '0;
        m_pend_err = 1;
      end else if (a_we[win]) begin
        m_bank[a_addr[win]] = a_wd[win];
        m_pend              = a_wd[win];
        m_pend_err          = 0;
      end else begin
        m_pend     = m_bank[a_addr[win]];
        m_pend_err = 0;
      end
      m_rsp_id = win;
      m_gid    = win;
      m_ptr    = (win + 1) % NR;
      m_since  = 1;
      acc_id.push_back(win);
      acc_cyc.push_back(cyc);
    end else if (m_since < 3) begin
      m_since++;
    end
    @(posedge clk);
    if (win >= 0) begin
      a_act[win] = refill;
      if (refill) a_wd[win] = {$urandom, $urandom};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      a_act[i]  = 0;
      a_we[i]   = 0;
      a_addr[i] = '0;
      a_wd[i]   = '0;
    end
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] wd);
    a_act[i]  = 1;
    a_we[i]   = we;
    a_addr[i] = AW'(addr);
    a_wd[i]   = wd;
  endtask

  initial begin
    reset  = 1'b0;
    refill = 0;
    clear_reqs();
    drive();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // single write then read from requester 0
    acc_id.delete(); acc_cyc.delete();
    obs_data = '1;
    set_req(0, 1, 3, 64'hDEAD_BEEF_0123_4567);
    run(4);
    chk("t2_accepts", acc_id.size(), 1);
    if (acc_cyc.size() > 0) chk("t2_latency", last_rsp_cyc - acc_cyc[0], 2);
    chk("t2_wr_data", obs_data, 64'hDEAD_BEEF_0123_4567);
    obs_data = '1;
    set_req(0, 0, 3, '0);
    run(4);
    chk("t2_rd_data", obs_data, 64'hDEAD_BEEF_0123_4567);
    chk("t2_rd_err", obs_err, 0);

    // all four requesters held valid: order 0,1,2,3,0 and 3-cycle spacing
    do_reset();
    clear_reqs();
    acc_id.delete(); acc_cyc.delete();
    refill = 1;
    for (int i = 0; i < NR; i++) set_req(i, $urandom_range(0, 1), $urandom_range(0, 5), {$urandom, $urandom});
    run(13);
    refill = 0;
    clear_reqs();
    run(4);
    chk("t3_count", acc_id.size() >= 5, 1);
    if (acc_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t3_order", acc_id[k], k % NR);
      for (int k = 1; k < 5; k++) chk("t3_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
    end

    // fairness: requester 2 keeps asking while requester 0 waits
    do_reset();
    clear_reqs();
    acc_id.delete(); acc_cyc.delete();
    set_req(2, 0, 0, '0);
    run(1);
    set_req(2, 0, 1, '0);
    set_req(0, 0, 2, '0);
    run(6);
    chk("t4_count", acc_id.size(), 3);
    if (acc_id.size() >= 3) begin
      chk("t4_first", acc_id[0], 2);
      chk("t4_second", acc_id[1], 0);
      chk("t4_third", acc_id[2], 2);
    end
    clear_reqs();
    run(3);

    // out of range accesses with DEPTH=6
    do_reset();
    clear_reqs();
    obs_data = '1;
    set_req(1, 1, 7, 64'h1234_5678_9ABC_DEF0);
    run(4);
    chk("t5_wr_err", obs_err, 1);
    obs_data = '1;
    set_req(1, 0, 7, '0);
    run(4);
    chk("t5_rd_data", obs_data, 0);
    chk("t5_rd_err", obs_err, 1);
    obs_data = '1;
    set_req(1, 0, 1, '0);
    run(4);
    chk("t5_alias_data", obs_data, 0);

    // reset while a write sits in ACCESS
    do_reset();
    clear_reqs();
    set_req(0, 1, 1, 64'd5);
    run(1);
    chk("t6_busy", busy, 1);
    do_reset();
    last_rsp_cyc = -1;
    run(4);
    chk("t6_no_rsp", last_rsp_cyc, -1);
    obs_data = '1;
    set_req(0, 0, 1, '0);
    run(4);
    chk("t6_rd_data", obs_data, 0);

    // randomized traffic with a reset in the middle
    do_reset();
    clear_reqs();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int i = 0; i < NR; i++) begin
        if (!a_act[i]) begin
          if ($urandom_range(0, 99) < 40)
            set_req(i, $urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom});
        end else if ($urandom_range(0, 99) < 5) begin
          a_act[i] = 0;
        end
      end
      step();
    end
    clear_reqs();
    run(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
